reg_mem_bist: RTL and testbench

//  Initiator/checker for reg_mem: drives its addr/data_in/wen port, sweeps a pattern through all
//  2**ADDR_BITS locations, reads every location back, compares and counts mismatches.

---
 rtl/reg_mem_bist.sv | 159 +++++++++++++++
 tb/tb_reg_mem_bist.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_mem_bist.sv
// Write/read-back BIST sweep for one reg_mem instance; counts mismatching locations.
// Optional BIST_ERRLOG_EN adds fail_addr/fail_data capture of the first mismatch.
module reg_mem_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS:0]    err_count
`ifdef BIST_ERRLOG_EN
    ,
    output logic [ADDR_BITS-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
`endif
);

    localparam logic [ADDR_BITS-1:0] LAST = '1;
    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DCW-1:0]       drain_cnt;
    logic                 start_acc;
    logic                 cmp_v;
    logic [ADDR_BITS-1:0] cmp_addr;
    logic                 mismatch;

    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [ADDR_BITS-1:0]  a,
        input logic [DATA_WIDTH-1:0] s
    );
        return DATA_WIDTH'(a) ^ s;
    endfunction

    assign start_acc = start && (state == S_IDLE || state == S_DONE);
    assign mem_addr  = addr;
    assign mem_wen   = (state == S_WRITE);
    assign busy      = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_count == '0);
    assign mismatch  = cmp_v && (mem_rdata != pat(cmp_addr, seed_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = S_WRITE;
            S_WRITE: if (addr == LAST) state_n = S_READ;
            S_READ:  if (addr == LAST) state_n = (RD_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_cnt == DCW'(RD_LAT - 1)) state_n = S_DONE;
            S_DONE:  if (start) state_n = S_WRITE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            mem_wdata <= '0;
            seed_q    <= '0;
            err_count <= '0;
            drain_cnt <= '0;
        end else begin
            if (mismatch) err_count <= err_count + (ADDR_BITS + 1)'(1);
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr      <= '0;
                        mem_wdata <= pat('0, seed);
                        seed_q    <= seed;
                        err_count <= '0;
                    end
                end
                S_WRITE: begin
                    if (addr == LAST) begin
                        addr <= '0;
                    end else begin
                        addr      <= addr + ADDR_BITS'(1);
                        mem_wdata <= pat(addr + ADDR_BITS'(1), seed_q);
                    end
                end
                S_READ: begin
                    drain_cnt <= '0;
                    if (addr != LAST) addr <= addr + ADDR_BITS'(1);
                end
                S_DRAIN: drain_cnt <= drain_cnt + DCW'(1);
                default: ;
            endcase
        end
    end

    // Read addresses travel down a RD_LAT-deep pipe to line up with mem_rdata
    if (RD_LAT > 0) begin : g_pipe
        logic [RD_LAT-1:0]                pipe_v;
        logic [RD_LAT-1:0][ADDR_BITS-1:0] pipe_a;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_v <= '0;
                pipe_a <= '0;
            end else begin
                pipe_v[0] <= (state == S_READ);
                pipe_a[0] <= addr;
                for (int i = 1; i < RD_LAT; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                    pipe_a[i] <= pipe_a[i-1];
                end
            end
        end

        assign cmp_v    = pipe_v[RD_LAT-1];
        assign cmp_addr = pipe_a[RD_LAT-1];
    end else begin : g_comb
        assign cmp_v    = (state == S_READ);
        assign cmp_addr = addr;
    end

`ifdef BIST_ERRLOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (start_acc) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch && err_count == '0) begin
            fail_addr <= cmp_addr;
            fail_data <= mem_rdata;
        end
    end
`else
    // no first-failure log in this build
`endif

endmodule

// File: tb/tb_reg_mem_bist.sv
// Bench for reg_mem_bist: 1-cycle memory model with injectable faults
// and a per-run expected error count computed from the pattern rule.
module tb_reg_mem_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wen;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_count;
`ifdef BIST_ERRLOG_EN
    logic [4:0] fail_addr;
    logic [7:0] fail_data;
`endif

    int checks = 0;
    int errors = 0;
    int fmode  = 0;

    logic [7:0] mem [32];
    logic [7:0] rd_q = 8'h00;
    logic [4:0] ra_q = 5'd0;

    reg_mem_bist #(
        .DATA_WIDTH(8),
        .ADDR_BITS (5),
        .RD_LAT    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed     (seed),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wen  (mem_wen),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count)
`ifdef BIST_ERRLOG_EN
        ,
        .fail_addr(fail_addr),
        .fail_data(fail_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fault(input logic [7:0] v, input int a, input int f);
        if (f == 2) return 8'hFF;
        if (f == 1 && a == 4) return v | 8'h01;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        rd_q <= mem[mem_addr];
        ra_q <= mem_addr;
    end

    always_comb mem_rdata = fault(rd_q, int'(ra_q), fmode);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run(input logic [7:0] s, input int f, input bit inj, input int rst_at);
        int         k;
        int         exp_err;
        int         fa;
        logic [7:0] fd;
        logic [7:0] e;
        logic [7:0] r;
        fmode = f;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int a = 0; a < 32; a++) begin
            e = 8'(a) ^ s;
            check("write_cycle", {18'd0, mem_wen, 5'(a) == mem_addr, mem_wdata},
                  {18'd0, 1'b1, 1'b1, e});
            if (s == 8'hA5 && a == 3) check("wdata_addr3", {24'd0, mem_wdata}, 32'hA6);
            check("busy_write", {31'd0, busy}, 32'd1);
            if (a == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_wen", {31'd0, mem_wen}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_errs", {26'd0, err_count}, 32'd0);
                check("rst_addr", {27'd0, mem_addr}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            start = inj && (a == 10);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_edge", k, 65);
        exp_err = 0;
        fa = -1;
        fd = 8'h00;
        for (int a = 0; a < 32; a++) begin
            e = 8'(a) ^ s;
            r = fault(e, a, f);
            if (r != e) begin
                exp_err++;
                if (fa < 0) begin
                    fa = a;
                    fd = r;
                end
            end
        end
        check("err_count", {26'd0, err_count}, exp_err);
        check("pass", {31'd0, pass}, {31'd0, exp_err == 0});
        check("busy_done", {31'd0, busy}, 32'd0);
`ifdef BIST_ERRLOG_EN
        check("fail_addr", {27'd0, fail_addr}, (fa < 0) ? 32'd0 : fa);
        check("fail_data", {24'd0, fail_data}, {24'd0, fd});
`endif
        @(negedge clk);
        check("done_hold", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_pass", {31'd0, pass}, 32'd0);
        check("reset_wen", {31'd0, mem_wen}, 32'd0);
        check("reset_errs", {26'd0, err_count}, 32'd0);
        check("reset_wdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);

        run(8'h00, 0, 1'b0, -1);
        run(8'hA5, 0, 1'b0, -1);
        run(8'h00, 1, 1'b0, -1);
        run(8'hE0, 2, 1'b0, -1);
        run(8'($urandom), 0, 1'b1, -1);
        run(8'($urandom), 0, 1'b0, 17);
        run(8'($urandom), 0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            run(8'($urandom), int'($urandom_range(0, 2)), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
